// File: rtl/decode_cycle_if.sv
// rtl/decode_cycle_if.sv - ID-stage pipeline signal bundle (fetch/WB/EX side and ID/EX register outputs)
interface decode_cycle_if;
  // from fetch, EX and WB
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic        is_taken_E;
  logic        rd_wren_W;
  logic [4:0]  rd_addr_W;
  logic [31:0] rd_data_W;
  // to fetch and EX
  logic        stall;
  logic [31:0] pc_E;
  logic [31:0] rs1_data_E;
  logic [31:0] rs2_data_E;
  logic [31:0] imm_E;
  logic [4:0]  rs1_addr_E;
  logic [4:0]  rs2_addr_E;
  logic [4:0]  rd_addr_E;
  logic [3:0]  alu_op_E;
  logic        op_a_sel_E;
  logic        op_b_sel_E;
  logic        br_un_E;
  logic        is_branch_E;
  logic        is_jump_E;
  logic        mem_rden_E;
  logic        mem_wren_E;
  logic [2:0]  ld_st_type_E;
  logic [1:0]  wb_sel_E;
  logic        rd_wren_E;
  logic        insn_vld_E;

  modport master (
    output instr_D, pc_D, is_taken_E, rd_wren_W, rd_addr_W, rd_data_W,
    input  stall, pc_E, rs1_data_E, rs2_data_E, imm_E, rs1_addr_E, rs2_addr_E, rd_addr_E,
           alu_op_E, op_a_sel_E, op_b_sel_E, br_un_E, is_branch_E, is_jump_E,
           mem_rden_E, mem_wren_E, ld_st_type_E, wb_sel_E, rd_wren_E, insn_vld_E
  );

  modport slave (
    input  instr_D, pc_D, is_taken_E, rd_wren_W, rd_addr_W, rd_data_W,
    output stall, pc_E, rs1_data_E, rs2_data_E, imm_E, rs1_addr_E, rs2_addr_E, rd_addr_E,
           alu_op_E, op_a_sel_E, op_b_sel_E, br_un_E, is_branch_E, is_jump_E,
           mem_rden_E, mem_wren_E, ld_st_type_E, wb_sel_E, rd_wren_E, insn_vld_E
  );
endinterface

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage: regfile, immediates, control, load-use stall, ID/EX register
module decode_cycle #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  decode_cycle_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  assign instr  = bus.instr_D;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  logic [XLEN-1:0] regs_q [NREG];

  // decoded (next-state) values for the ID/EX register
  logic [XLEN-1:0] rs1_data_d, rs2_data_d, imm_d;
  logic [3:0]      alu_op_d;
  logic            op_a_sel_d, op_b_sel_d, br_un_d, is_branch_d, is_jump_d;
  logic            mem_rden_d, mem_wren_d, rd_wren_d, insn_vld_d;
  logic [2:0]      ld_st_type_d;
  logic [1:0]      wb_sel_d;
  logic            use_rs1, use_rs2, bubble;

  // ID/EX register
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]      rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [3:0]      alu_op_q;
  logic            op_a_sel_q, op_b_sel_q, br_un_q, is_branch_q, is_jump_q;
  logic            mem_rden_q, mem_wren_q, rd_wren_q, insn_vld_q;
  logic [2:0]      ld_st_type_q;
  logic [1:0]      wb_sel_q;

  // register file read with same-cycle WB bypass; x0 is hardwired to zero
  always_comb begin
    rs1_data_d = '0;
    rs2_data_d = '0;
    if (rs1 != 5'd0)
      rs1_data_d = (bus.rd_wren_W && bus.rd_addr_W == rs1) ? bus.rd_data_W : regs_q[rs1];
    if (rs2 != 5'd0)
      rs2_data_d = (bus.rd_wren_W && bus.rd_addr_W == rs2) ? bus.rd_data_W : regs_q[rs2];
  end

  // instruction decode: immediate, control bundle and which sources are really read
  always_comb begin
    imm_d        = '0;
    alu_op_d     = ALU_ADD;
    op_a_sel_d   = 1'b0;
    op_b_sel_d   = 1'b0;
    br_un_d      = 1'b0;
    is_branch_d  = 1'b0;
    is_jump_d    = 1'b0;
    mem_rden_d   = 1'b0;
    mem_wren_d   = 1'b0;
    ld_st_type_d = 3'd0;
    wb_sel_d     = 2'd0;
    rd_wren_d    = 1'b0;
    insn_vld_d   = 1'b1;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_d = {instr[31:12], 12'b0};
        alu_op_d = ALU_PASS_B; op_b_sel_d = 1'b1; rd_wren_d = 1'b1;
      end
      OPC_AUIPC: begin
        imm_d = {instr[31:12], 12'b0};
        op_a_sel_d = 1'b1; op_b_sel_d = 1'b1; rd_wren_d = 1'b1;
      end
      OPC_JAL: begin
        imm_d = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        op_a_sel_d = 1'b1; op_b_sel_d = 1'b1; wb_sel_d = 2'd2; is_jump_d = 1'b1; rd_wren_d = 1'b1;
      end
      OPC_JALR: begin
        imm_d = {{20{instr[31]}}, instr[31:20]};
        op_b_sel_d = 1'b1; wb_sel_d = 2'd2; is_jump_d = 1'b1; rd_wren_d = 1'b1; use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        imm_d = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        op_a_sel_d = 1'b1; op_b_sel_d = 1'b1; is_branch_d = 1'b1; br_un_d = funct3[1];
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        imm_d = {{20{instr[31]}}, instr[31:20]};
        op_b_sel_d = 1'b1; mem_rden_d = 1'b1; wb_sel_d = 2'd1; ld_st_type_d = funct3;
        rd_wren_d = 1'b1; use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        op_b_sel_d = 1'b1; mem_wren_d = 1'b1; ld_st_type_d = funct3;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OPIMM, OPC_OP: begin
        if (opcode == OPC_OPIMM) begin
          imm_d = {{20{instr[31]}}, instr[31:20]};
          op_b_sel_d = 1'b1;
        end else begin
          use_rs2 = 1'b1;
        end
        use_rs1 = 1'b1; rd_wren_d = 1'b1;
        case (funct3)
          3'd0:    alu_op_d = (opcode == OPC_OP && instr[30]) ? ALU_SUB : ALU_ADD;
          3'd1:    alu_op_d = ALU_SLL;
          3'd2:    alu_op_d = ALU_SLT;
          3'd3:    alu_op_d = ALU_SLTU;
          3'd4:    alu_op_d = ALU_XOR;
          3'd5:    alu_op_d = instr[30] ? ALU_SRA : ALU_SRL;
          3'd6:    alu_op_d = ALU_OR;
          default: alu_op_d = ALU_AND;
        endcase
      end
      default: insn_vld_d = 1'b0;
    endcase
    if (rd == 5'd0) rd_wren_d = 1'b0;
  end

  // load-use hazard against the load sitting in EX; a taken branch cancels it
  assign bus.stall = rst_ni && !bus.is_taken_E && mem_rden_q && (rd_addr_q != 5'd0) &&
                     ((use_rs1 && rs1 == rd_addr_q) || (use_rs2 && rs2 == rd_addr_q));
  assign bubble    = !insn_vld_d || bus.stall || bus.is_taken_E;

  // register file write port; x0 is never written
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (bus.rd_wren_W && bus.rd_addr_W != 5'd0) begin
      regs_q[bus.rd_addr_W] <= bus.rd_data_W;
    end
  end

  // ID/EX register: data and addresses always advance, control is cleared for a bubble
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= '0; rs1_data_q <= '0; rs2_data_q <= '0; imm_q <= '0;
      rs1_addr_q <= '0; rs2_addr_q <= '0; rd_addr_q <= '0;
      alu_op_q <= '0; op_a_sel_q <= 1'b0; op_b_sel_q <= 1'b0; br_un_q <= 1'b0;
      is_branch_q <= 1'b0; is_jump_q <= 1'b0; mem_rden_q <= 1'b0; mem_wren_q <= 1'b0;
      ld_st_type_q <= '0; wb_sel_q <= '0; rd_wren_q <= 1'b0; insn_vld_q <= 1'b0;
    end else begin
      pc_q <= bus.pc_D; rs1_data_q <= rs1_data_d; rs2_data_q <= rs2_data_d; imm_q <= imm_d;
      rs1_addr_q <= rs1; rs2_addr_q <= rs2; rd_addr_q <= rd;
      alu_op_q     <= bubble ? 4'd0 : alu_op_d;
      op_a_sel_q   <= !bubble && op_a_sel_d;
      op_b_sel_q   <= !bubble && op_b_sel_d;
      br_un_q      <= !bubble && br_un_d;
      is_branch_q  <= !bubble && is_branch_d;
      is_jump_q    <= !bubble && is_jump_d;
      mem_rden_q   <= !bubble && mem_rden_d;
      mem_wren_q   <= !bubble && mem_wren_d;
      ld_st_type_q <= bubble ? 3'd0 : ld_st_type_d;
      wb_sel_q     <= bubble ? 2'd0 : wb_sel_d;
      rd_wren_q    <= !bubble && rd_wren_d;
      insn_vld_q   <= !bubble;
    end
  end

  assign bus.pc_E         = pc_q;
  assign bus.rs1_data_E   = rs1_data_q;
  assign bus.rs2_data_E   = rs2_data_q;
  assign bus.imm_E        = imm_q;
  assign bus.rs1_addr_E   = rs1_addr_q;
  assign bus.rs2_addr_E   = rs2_addr_q;
  assign bus.rd_addr_E    = rd_addr_q;
  assign bus.alu_op_E     = alu_op_q;
  assign bus.op_a_sel_E   = op_a_sel_q;
  assign bus.op_b_sel_E   = op_b_sel_q;
  assign bus.br_un_E      = br_un_q;
  assign bus.is_branch_E  = is_branch_q;
  assign bus.is_jump_E    = is_jump_q;
  assign bus.mem_rden_E   = mem_rden_q;
  assign bus.mem_wren_E   = mem_wren_q;
  assign bus.ld_st_type_E = ld_st_type_q;
  assign bus.wb_sel_E     = wb_sel_q;
  assign bus.rd_wren_E    = rd_wren_q;
  assign bus.insn_vld_E   = insn_vld_q;

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - randomized and directed bench for decode_cycle with a behavioural decode model
module tb_decode_cycle;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  decode_cycle_if bus();
  decode_cycle dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rda;
    logic [3:0]  alu;
    logic        asel, bsel, brun, isbr, isj, mrd, mwr;
    logic [2:0]  lst;
    logic [1:0]  wbs;
    logic        wr, vld;
  } e_t;

  logic [31:0] m_regs [32];
  e_t m_e;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic e_t observed();
    e_t o;
    o.pc = bus.pc_E; o.rs1d = bus.rs1_data_E; o.rs2d = bus.rs2_data_E; o.imm = bus.imm_E;
    o.rs1a = bus.rs1_addr_E; o.rs2a = bus.rs2_addr_E; o.rda = bus.rd_addr_E; o.alu = bus.alu_op_E;
    o.asel = bus.op_a_sel_E; o.bsel = bus.op_b_sel_E; o.brun = bus.br_un_E;
    o.isbr = bus.is_branch_E; o.isj = bus.is_jump_E; o.mrd = bus.mem_rden_E; o.mwr = bus.mem_wren_E;
    o.lst = bus.ld_st_type_E; o.wbs = bus.wb_sel_E; o.wr = bus.rd_wren_E; o.vld = bus.insn_vld_E;
    return o;
  endfunction

  // architectural register read as seen this cycle, including the WB write landing now
  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.rd_wren_W && bus.rd_addr_W == a) return bus.rd_data_W;
    return m_regs[a];
  endfunction

  function automatic void ref_uses(input logic [31:0] ins, output bit u1, output bit u2);
    u1 = 0; u2 = 0;
    case (ins[6:0])
      7'h67, 7'h03, 7'h13: u1 = 1;
      7'h63, 7'h23, 7'h33: begin u1 = 1; u2 = 1; end
      default: ;
    endcase
  endfunction

  function automatic bit ref_stall();
    bit u1, u2;
    if (!rst_ni || bus.is_taken_E) return 0;
    if (!m_e.mrd || m_e.rda == 5'd0) return 0;
    ref_uses(bus.instr_D, u1, u2);
    return (u1 && bus.instr_D[19:15] == m_e.rda) || (u2 && bus.instr_D[24:20] == m_e.rda);
  endfunction

  function automatic e_t ref_next(input logic [31:0] ins, input logic [31:0] pc, input bit kill);
    e_t e = '0;
    int f3_alu [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [2:0] f3 = ins[14:12];
    e.pc = pc; e.rs1a = ins[19:15]; e.rs2a = ins[24:20]; e.rda = ins[11:7];
    e.rs1d = ref_read(e.rs1a); e.rs2d = ref_read(e.rs2a);
    e.vld = 1;
    case (ins[6:0])
      7'h37: begin e.imm = {ins[31:12], 12'h000}; e.alu = 10; e.bsel = 1; e.wr = 1; end
      7'h17: begin e.imm = {ins[31:12], 12'h000}; e.asel = 1; e.bsel = 1; e.wr = 1; end
      7'h6f: begin
        e.imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        e.asel = 1; e.bsel = 1; e.wbs = 2; e.isj = 1; e.wr = 1;
      end
      7'h67: begin e.imm = $signed(ins[31:20]); e.bsel = 1; e.wbs = 2; e.isj = 1; e.wr = 1; end
      7'h63: begin
        e.imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        e.asel = 1; e.bsel = 1; e.isbr = 1; e.brun = f3[1];
      end
      7'h03: begin e.imm = $signed(ins[31:20]); e.bsel = 1; e.mrd = 1; e.wbs = 1; e.lst = f3; e.wr = 1; end
      7'h23: begin e.imm = $signed({ins[31:25], ins[11:7]}); e.bsel = 1; e.mwr = 1; e.lst = f3; end
      7'h13, 7'h33: begin
        e.wr = 1;
        e.alu = 4'(f3_alu[f3]);
        if (f3 == 3'd5 && ins[30]) e.alu = 7;
        if (ins[6:0] == 7'h33 && f3 == 3'd0 && ins[30]) e.alu = 1;
        if (ins[6:0] == 7'h13) begin e.imm = $signed(ins[31:20]); e.bsel = 1; end
      end
      default: e.vld = 0;
    endcase
    if (e.rda == 5'd0) e.wr = 0;
    if (kill || !e.vld) begin
      e.alu = 0; e.asel = 0; e.bsel = 0; e.brun = 0; e.isbr = 0; e.isj = 0;
      e.mrd = 0; e.mwr = 0; e.lst = 0; e.wbs = 0; e.wr = 0; e.vld = 0;
    end
    return e;
  endfunction

  // advance one clock: sample stall before the edge, update the model across it
  task automatic tick(output logic st_obs, output bit st_exp);
    e_t nxt;
    #1;
    st_exp = ref_stall();
    st_obs = bus.stall;
    nxt = !rst_ni ? e_t'(0) : ref_next(bus.instr_D, bus.pc_D, st_exp || bus.is_taken_E);
    @(posedge clk_i);
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else if (bus.rd_wren_W && bus.rd_addr_W != 5'd0) begin
      m_regs[bus.rd_addr_W] = bus.rd_data_W;
    end
    m_e = nxt;
    #1;
  endtask

  task automatic read_all_zero(input string tag);
    logic so; bit se;
    for (int i = 1; i < 32; i++) begin
      bus.instr_D = {7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'h33};
      tick(so, se);
      n_checks++;
      if (bus.rs1_data_E !== 32'd0 || bus.rs2_data_E !== 32'd0) begin
        n_fail++;
        $display("FAIL %s x%0d: got rs1=%h rs2=%h, want 0", tag, i, bus.rs1_data_E, bus.rs2_data_E);
      end
    end
  endtask

  task automatic test_reset();
    logic so; bit se;
    rst_ni = 0;
    bus.instr_D = 32'h0000A283; bus.pc_D = 32'h100; bus.is_taken_E = 0;
    bus.rd_wren_W = 1; bus.rd_addr_W = 5'd7; bus.rd_data_W = 32'h55AA55AA;
    for (int c = 0; c < 2; c++) begin
      tick(so, se);
      n_checks++;
      if (so !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", so); end
    end
    n_checks++;
    if (observed() !== e_t'(0)) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", observed()); end
    rst_ni = 1; bus.rd_wren_W = 0;
    read_all_zero("reset_regfile");
  endtask

  task automatic test_addi();
    logic so; bit se;
    bus.instr_D = 32'h00500093; bus.pc_D = 32'h10;
    tick(so, se);
    n_checks++;
    if (bus.imm_E !== 32'd5 || bus.rd_addr_E !== 5'd1 || bus.alu_op_E !== 4'd0 ||
        bus.op_b_sel_E !== 1'b1 || bus.rd_wren_E !== 1'b1 || bus.pc_E !== 32'h10 || bus.insn_vld_E !== 1'b1) begin
      n_fail++;
      $display("FAIL addi: got imm=%h rd=%0d alu=%0d bsel=%b wr=%b pc=%h vld=%b want 5/1/0/1/1/10/1",
               bus.imm_E, bus.rd_addr_E, bus.alu_op_E, bus.op_b_sel_E, bus.rd_wren_E, bus.pc_E, bus.insn_vld_E);
    end
  endtask

  task automatic test_bypass();
    logic so; bit se;
    bus.rd_wren_W = 1; bus.rd_addr_W = 5'd3; bus.rd_data_W = 32'hDEADBEEF;
    bus.instr_D = 32'h00018213;
    tick(so, se);
    n_checks++;
    if (bus.rs1_data_E !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass: got %h want deadbeef", bus.rs1_data_E);
    end
    bus.rd_wren_W = 0;
    tick(so, se);
    n_checks++;
    if (bus.rs1_data_E !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL regfile_hold: got %h want deadbeef", bus.rs1_data_E);
    end
  endtask

  task automatic test_x0();
    logic so; bit se;
    bus.rd_wren_W = 1; bus.rd_addr_W = 5'd0; bus.rd_data_W = 32'h1234;
    bus.instr_D = 32'h00500093;
    tick(so, se);
    n_checks++;
    if (bus.rs1_data_E !== 32'd0) begin n_fail++; $display("FAIL x0_bypass: got %h want 0", bus.rs1_data_E); end
    bus.rd_wren_W = 0;
    tick(so, se);
    n_checks++;
    if (bus.rs1_data_E !== 32'd0) begin n_fail++; $display("FAIL x0_read: got %h want 0", bus.rs1_data_E); end
  endtask

  task automatic test_load_use();
    logic so; bit se;
    bus.instr_D = 32'h0000A283; bus.pc_D = 32'h20;
    tick(so, se);
    n_checks++;
    if (so !== 1'b0 || bus.mem_rden_E !== 1'b1 || bus.rd_addr_E !== 5'd5 || bus.wb_sel_E !== 2'd1 || bus.ld_st_type_E !== 3'd2) begin
      n_fail++; $display("FAIL lw_decode: got stall=%b rden=%b rd=%0d wbs=%0d lst=%0d want 0/1/5/1/2",
                         so, bus.mem_rden_E, bus.rd_addr_E, bus.wb_sel_E, bus.ld_st_type_E);
    end
    bus.instr_D = 32'h00228333; bus.pc_D = 32'h24;
    tick(so, se);
    n_checks++;
    if (so !== 1'b1 || bus.insn_vld_E !== 1'b0 || bus.rd_wren_E !== 1'b0) begin
      n_fail++; $display("FAIL load_use_stall: got stall=%b vld=%b wr=%b want 1/0/0", so, bus.insn_vld_E, bus.rd_wren_E);
    end
    tick(so, se);
    n_checks++;
    if (so !== 1'b0 || bus.insn_vld_E !== 1'b1 || bus.rs1_addr_E !== 5'd5 || bus.rd_addr_E !== 5'd6 || bus.alu_op_E !== 4'd0) begin
      n_fail++; $display("FAIL load_use_issue: got stall=%b vld=%b rs1=%0d rd=%0d alu=%0d want 0/1/5/6/0",
                         so, bus.insn_vld_E, bus.rs1_addr_E, bus.rd_addr_E, bus.alu_op_E);
    end
  endtask

  task automatic test_branch_flush();
    logic so; bit se;
    bus.instr_D = 32'hFE000CE3; bus.pc_D = 32'h40;
    tick(so, se);
    n_checks++;
    if (bus.imm_E !== 32'hFFFFFFF8 || bus.is_branch_E !== 1'b1 || bus.op_a_sel_E !== 1'b1 || bus.insn_vld_E !== 1'b1) begin
      n_fail++; $display("FAIL beq: got imm=%h br=%b asel=%b vld=%b want fffffff8/1/1/1",
                         bus.imm_E, bus.is_branch_E, bus.op_a_sel_E, bus.insn_vld_E);
    end
    bus.instr_D = 32'h0000A283;
    tick(so, se);
    bus.instr_D = 32'h00228333; bus.is_taken_E = 1;
    tick(so, se);
    n_checks++;
    if (so !== 1'b0 || bus.insn_vld_E !== 1'b0 || bus.mem_rden_E !== 1'b0) begin
      n_fail++; $display("FAIL flush_over_stall: got stall=%b vld=%b rden=%b want 0/0/0", so, bus.insn_vld_E, bus.mem_rden_E);
    end
    bus.is_taken_E = 0;
    tick(so, se);
    n_checks++;
    if (so !== 1'b0 || bus.insn_vld_E !== 1'b1) begin
      n_fail++; $display("FAIL after_flush: got stall=%b vld=%b want 0/1", so, bus.insn_vld_E);
    end
  endtask

  task automatic test_reset_mid();
    logic so; bit se;
    bus.instr_D = 32'd0;
    for (int i = 1; i < 32; i++) begin
      bus.rd_wren_W = 1; bus.rd_addr_W = 5'(i); bus.rd_data_W = $urandom | 32'h1;
      tick(so, se);
    end
    bus.rd_wren_W = 0;
    bus.instr_D = 32'h0000A283;
    tick(so, se);
    bus.instr_D = 32'h00228333; bus.is_taken_E = 1; rst_ni = 0;
    tick(so, se);
    n_checks++;
    if (so !== 1'b0 || observed() !== e_t'(0)) begin
      n_fail++; $display("FAIL reset_mid: got stall=%b out=%h want 0/0", so, observed());
    end
    rst_ni = 1; bus.is_taken_E = 0;
    bus.instr_D = 32'h00500093; bus.pc_D = 32'h20;
    tick(so, se);
    n_checks++;
    if (bus.insn_vld_E !== 1'b1 || bus.imm_E !== 32'd5 || bus.pc_E !== 32'h20) begin
      n_fail++; $display("FAIL reset_release: got vld=%b imm=%h pc=%h want 1/5/20", bus.insn_vld_E, bus.imm_E, bus.pc_E);
    end
    read_all_zero("reset_mid_regfile");
  endtask

  task automatic test_random();
    logic so; bit se;
    logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7f, 7'h00};
    bit held = 0;
    int n_stalls = 0;
    for (int c = 0; c < 600; c++) begin
      if (!held) begin
        logic [31:0] r = $urandom;
        logic [4:0] a1 = 5'($urandom_range(0, 3));
        logic [4:0] a2 = 5'($urandom_range(0, 3));
        logic [4:0] ad = 5'($urandom_range(0, 3));
        logic [6:0] op = opcs[$urandom_range(0, 10)];
        if ($urandom_range(0, 3) == 0) op = 7'h03;
        bus.instr_D = {r[31:25], a2, a1, r[14:12], ad, op};
        if ($urandom_range(0, 15) == 0) bus.instr_D = 32'd0;
        bus.pc_D = $urandom & 32'hFFFF_FFFC;
      end
      bus.is_taken_E = ($urandom_range(0, 7) == 0);
      bus.rd_wren_W  = $urandom_range(0, 1);
      bus.rd_addr_W  = 5'($urandom_range(0, 4));
      bus.rd_data_W  = $urandom;
      tick(so, se);
      held = se;
      if (se) n_stalls++;
      n_checks++;
      if (so !== logic'(se)) begin
        n_fail++; $display("FAIL rand_stall c%0d: got %b want %b instr=%h", c, so, se, bus.instr_D);
      end
      n_checks++;
      if (observed() !== m_e) begin
        n_fail++; $display("FAIL rand_out c%0d: got %h want %h", c, observed(), m_e);
      end
    end
    n_checks++;
    if (n_stalls == 0) begin n_fail++; $display("FAIL rand_stall_seen: got 0 stalls want >0"); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_e = '0;
    rst_ni = 0;
    bus.instr_D = 0; bus.pc_D = 0; bus.is_taken_E = 0;
    bus.rd_wren_W = 0; bus.rd_addr_W = 0; bus.rd_data_W = 0;
    test_reset();
    test_addi();
    test_bypass();
    test_x0();
    test_load_use();
    test_branch_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
